// File: rtl/dmem_dump_reader.sv
// Streams a contiguous range of data-memory words out on a valid/ready port.
// Reads run ahead of the consumer into a skid FIFO placed behind the output register.
module dmem_dump_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last
);
   // state  | meaning
   // S_IDLE | waiting for start
   // S_RUN  | issuing reads and streaming words
   // S_DONE | one-cycle completion pulse
   localparam int EW = DATA_W + ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   remaining;
   logic              infl, infl_last;
   logic [ADDR_W-1:0] infl_addr;
   logic [EW-1:0]     fifo0, fifo1, push_entry;
   logic [1:0]        fifo_cnt, reserved;
   logic              pop, push, load_direct, push_fifo, pop_fifo;

   // Slots are reserved at issue time, so a stalled consumer never loses a word.
   always_comb begin
      reserved    = fifo_cnt + {1'b0, infl};
      mem_rd_en   = (state == S_RUN) && (remaining != '0) && (reserved < 2'd2);
      pop         = out_valid && out_ready;
      push        = infl;
      push_entry  = {infl_last, infl_addr, mem_rd_data};
      load_direct = push && (!out_valid || (pop && fifo_cnt == 2'd0));
      push_fifo   = push && !load_direct;
      pop_fifo    = pop && (fifo_cnt != 2'd0);
      busy        = (state == S_RUN);
      done        = (state == S_DONE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (word_count == '0) ? S_DONE : S_RUN;
         S_RUN:   if (pop && out_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remaining <= '0;
         mem_addr  <= '0;
         infl      <= 1'b0;
         infl_addr <= '0;
         infl_last <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            remaining <= word_count;
            mem_addr  <= base_addr;
         end else if (mem_rd_en) begin
            remaining <= remaining - 1'b1;
            mem_addr  <= mem_addr + 1'b1;
         end
         infl <= mem_rd_en;
         if (mem_rd_en) begin
            infl_addr <= mem_addr;
            infl_last <= (remaining == {{ADDR_W{1'b0}}, 1'b1});
         end
      end
   end

   // The output register is the stream head; the FIFO only fills while it stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         fifo0     <= '0;
         fifo1     <= '0;
         fifo_cnt  <= 2'd0;
      end else begin
         if (pop_fifo) begin
            {out_last, out_addr, out_data} <= fifo0;
            out_valid <= 1'b1;
            fifo0     <= fifo1;
         end else if (load_direct) begin
            {out_last, out_addr, out_data} <= push_entry;
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
         if (push_fifo) begin
            if (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop_fifo)) fifo0 <= push_entry;
            else                                                   fifo1 <= push_entry;
         end
         case ({push_fifo, pop_fifo})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end
endmodule
